// File: rtl/saes_if.sv
// saes_if: request/response bundle for saes_encrypt_ctrl.
// master issues requests and takes results; slave is the engine.
interface saes_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_in;
   logic [15:0] key_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] data_out;
   logic        busy;

   modport master (
      output in_valid, data_in, key_in, out_ready,
      input  in_ready, out_valid, data_out, busy
   );

   modport slave (
      input  in_valid, data_in, key_in, out_ready,
      output in_ready, out_valid, data_out, busy
   );
endinterface

// File: rtl/saes_encrypt_ctrl.sv
// saes_encrypt_ctrl: multi-cycle S-AES encryption controller.
// Define SAES_KEY_CACHE_EN to reuse K1/K2 when the key repeats.
module saes_encrypt_ctrl (
   input  logic clk,
   input  logic rst,
   saes_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, KEXP1, KEXP2, RK0, RND1, RND2, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pt_q, pt_d;
   logic [15:0] k0_q, k0_d;
   logic [15:0] k1_q, k1_d;
   logic [15:0] k2_q, k2_d;
   logic [15:0] st_q, st_d;
   logic [15:0] dout_q, dout_d;
   logic        live_q, live_d;
   logic        accept;
   logic        hit;

   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'h9;
         4'h1: r = 4'h4;
         4'h2: r = 4'hA;
         4'h3: r = 4'hB;
         4'h4: r = 4'hD;
         4'h5: r = 4'h1;
         4'h6: r = 4'h8;
         4'h7: r = 4'h5;
         4'h8: r = 4'h6;
         4'h9: r = 4'h2;
         4'hA: r = 4'h0;
         4'hB: r = 4'h3;
         4'hC: r = 4'hC;
         4'hD: r = 4'hE;
         4'hE: r = 4'hF;
         4'hF: r = 4'h7;
      endcase
      return r;
   endfunction

   // SubNib(RotNib(w)): swap nibbles, then substitute each
   function automatic logic [7:0] sub_rot(input logic [7:0] w);
      return {sbox(w[3:0]), sbox(w[7:4])};
   endfunction

   // one key-schedule step: {wa, wb} -> {wc, wd}
   function automatic logic [15:0] kstep(
      input logic [15:0] k,
      input logic [7:0]  rc
   );
      logic [7:0] a;
      a = k[15:8] ^ rc ^ sub_rot(k[7:0]);
      return {a, a ^ k[7:0]};
   endfunction

   function automatic logic [15:0] sub16(input logic [15:0] s);
      return {sbox(s[15:12]), sbox(s[11:8]),
              sbox(s[7:4]), sbox(s[3:0])};
   endfunction

   // row 1 of the 2x2 state is n1/n3
   function automatic logic [15:0] shr(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [3:0] xt(input logic [3:0] n);
      return {n[2:0], 1'b0} ^ (n[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] m4(input logic [3:0] n);
      return xt(xt(n));
   endfunction

   // columns are (n0,n1) and (n2,n3); matrix [1 4; 4 1]
   function automatic logic [15:0] mix(input logic [15:0] s);
      return {s[15:12] ^ m4(s[11:8]),
              m4(s[15:12]) ^ s[11:8],
              s[7:4] ^ m4(s[3:0]),
              m4(s[7:4]) ^ s[3:0]};
   endfunction

   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.in_ready  = (state_q == IDLE) & live_q;
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.data_out  = dout_q;

`ifdef SAES_KEY_CACHE_EN
   logic [15:0] ck_key_q, ck_key_d;
   logic [15:0] ck_k1_q, ck_k1_d;
   logic [15:0] ck_k2_q, ck_k2_d;
   logic        ck_vld_q, ck_vld_d;

   assign hit = ck_vld_q & (bus.key_in == ck_key_q);

   // fill the cache once a full key expansion completes
   always_comb begin
      ck_key_d = ck_key_q;
      ck_k1_d  = ck_k1_q;
      ck_k2_d  = ck_k2_q;
      ck_vld_d = ck_vld_q;
      if (state_q == KEXP2) begin
         ck_key_d = k0_q;
         ck_k1_d  = k1_q;
         ck_k2_d  = kstep(k1_q, 8'h30);
         ck_vld_d = 1'b1;
      end
   end

   // cache registers; reset invalidates the entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ck_key_q <= 16'h0000;
         ck_k1_q  <= 16'h0000;
         ck_k2_q  <= 16'h0000;
         ck_vld_q <= 1'b0;
      end else begin
         ck_key_q <= ck_key_d;
         ck_k1_q  <= ck_k1_d;
         ck_k2_q  <= ck_k2_d;
         ck_vld_q <= ck_vld_d;
      end
   end
`else
   assign hit = 1'b0;
`endif

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = hit ? RK0 : KEXP1;
         KEXP1:   state_d = KEXP2;
         KEXP2:   state_d = RK0;
         RK0:     state_d = RND1;
         RND1:    state_d = RND2;
         RND2:    state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // datapath: capture, key expansion and rounds
   always_comb begin
      pt_d   = pt_q;
      k0_d   = k0_q;
      k1_d   = k1_q;
      k2_d   = k2_q;
      st_d   = st_q;
      dout_d = dout_q;
      live_d = 1'b1;
      case (state_q)
         IDLE: if (accept) begin
            pt_d = bus.data_in;
            k0_d = bus.key_in;
`ifdef SAES_KEY_CACHE_EN
            if (hit) begin
               k1_d = ck_k1_q;
               k2_d = ck_k2_q;
            end
`endif
         end
         KEXP1:   k1_d = kstep(k0_q, 8'h80);
         KEXP2:   k2_d = kstep(k1_q, 8'h30);
         RK0:     st_d = pt_q ^ k0_q;
         RND1:    st_d = mix(shr(sub16(st_q))) ^ k1_q;
         RND2:    dout_d = shr(sub16(st_q)) ^ k2_q;
         default: ;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pt_q    <= 16'h0000;
         k0_q    <= 16'h0000;
         k1_q    <= 16'h0000;
         k2_q    <= 16'h0000;
         st_q    <= 16'h0000;
         dout_q  <= 16'h0000;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pt_q    <= pt_d;
         k0_q    <= k0_d;
         k1_q    <= k1_d;
         k2_q    <= k2_d;
         st_q    <= st_d;
         dout_q  <= dout_d;
         live_q  <= live_d;
      end
   end
endmodule
